pipe_stage: RTL
===============

# pipe_stage

Parametrised pipeline stage register that generalises the fixed-field EX-stage latch into a reusable valid/ready stage. It serves the ID/EX, EX/MEM and MEM/WB boundaries. It keeps hold (backpressure) and bubble insertion (flush) as separate controls, and it zeroes only the control payload on a bubble. It also keeps a saturating count of backpressure cycles for performance analysis.

## Interface
Parameters:
- CTRL_W, 16, width of control payload (RegWr, MemWr, MemToReg, Jump, Jal, AluCtrl, ...); zeroed on bubble.
- DATA_W, 128, width of data payload (BusA, BusB, Imm32, Inst, ...); never zeroed except at reset.
- CNT_W, 16, width of stall counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  control payload.
- in_data  in  DATA_W  data payload.
- flush  in  1  kill contents, insert bubble (branch/jump redirect).
- out_valid  out  1  output holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control payload; 0 whenever out_valid=0.
- out_data  out  DATA_W  data payload.
- stall_cnt  out  CNT_W  cycles spent backpressured.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Accept = in_valid & in_ready; Emit = out_valid & out_ready.
- Base mode (PIPE_SKID_EN undefined):
  - There is one register.
  - in_ready = ~out_valid | out_ready (combinational).
  - On Accept the register loads in_ctrl/in_data and out_valid becomes 1.
  - On Emit without Accept, out_valid becomes 0 and out_ctrl becomes 0. out_data holds its value.
  - With neither Accept nor Emit, the register holds.
- flush:
  - Next cycle, out_valid=0 and out_ctrl=0 (and the skid entry is cleared if present).
  - flush has priority over a simultaneous Accept; the accepted beat is discarded.
  - in_ready is unaffected by flush in the flush cycle.
- Stall counter:
  - Increments when out_valid & ~out_ready and flush=0.
  - Saturates at 2^CNT_W-1; there is no wrap-around.
  - stall_cnt_clr sets it to 0 next cycle and has priority over increment.
- Reset mid-operation discards all contents immediately (asynchronous).

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - in_ready=1 in both modes (in base mode because out_valid=0).
- Latency is 1 cycle from Accept to out_valid.
- Throughput is 1 beat/cycle with out_ready held at 1.
- Handshake rules:
  - out_ctrl and out_data are stable while out_valid=1 and out_ready=0.
  - The stage never drops or duplicates a beat except on flush.

## Configuration
- Macro PIPE_SKID_EN.
- Defined: a 2-entry skid buffer (main + skid) makes in_ready a registered output, breaking the combinational ready path across stages.
  - States: EMPTY (out_valid=0), ONE (main full), TWO (main+skid full).
  - EMPTY→ONE on Accept.
  - ONE→TWO on Accept without Emit.
  - ONE→EMPTY on Emit without Accept.
  - ONE stays ONE on Accept with Emit.
  - TWO→ONE on Emit: skid moves to main.
  - in_ready = (state≠TWO), registered. It is never 1 in TWO, so there is no Accept in TWO.
  - flush from any state → EMPTY and in_ready=1 next cycle.
  - Latency is still 1 cycle.
- Undefined: base mode as in Operation; no skid storage, no state register.

## Structure
- Package pipe_pkg holds:
  - typedef enum for skid states EMPTY/ONE/TWO;
  - default width constants PIPE_CTRL_W=16, PIPE_DATA_W=128, PIPE_CNT_W=16.
- Sub-module pipe_skid_buf: the 2-entry buffer and state machine, instantiated only under PIPE_SKID_EN.
- The stall counter and flush gating stay in pipe_stage.

## Test plan
- Streaming: in_valid=1 with in_ctrl=i, in_data=i*3 for i=1..8, out_ready=1 → out_valid=1 from cycle 1, out_ctrl=1..8 in order, stall_cnt stays 0.
- Backpressure: load ctrl=0x00A5, out_ready=0 for 5 cycles → out_ctrl holds 0x00A5, stall_cnt=5. In skid mode, a second beat 0x005A is accepted and in_ready=0 thereafter. Release → 0x00A5 then 0x005A.
- Flush with simultaneous accept: out_valid=1, flush=1 and in_valid=1 (ctrl=0x1234) in the same cycle → next cycle out_valid=0, out_ctrl=0. 0x1234 never appears at the output.
- Saturation/clear: CNT_W=4, out_ready=0 for 20 cycles → stall_cnt=15. Assert stall_cnt_clr together with a stall → stall_cnt=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while in TWO/ONE → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 immediately; in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipe_stage valid/ready register slice.
// The skid-buffer state type is only used when PIPE_SKID_EN is defined.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) buffer with a registered in_ready, used by pipe_stage
// when PIPE_SKID_EN is defined. Control payload is zeroed whenever an entry is empty.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              accept_s, emit_s;

    // Next-state and datapath selection for the two entries.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        accept_s    = in_valid & in_ready_q;
        emit_s      = out_valid_q & out_ready;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
            skid_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && emit_s) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept_s) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = TWO;
                    end else if (emit_s) begin
                        main_ctrl_d = {CTRL_W{1'b0}};
                        state_d     = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (emit_s) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = {CTRL_W{1'b0}};
                        state_d     = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = {CTRL_W{1'b0}};
                    skid_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    // State, entries and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= {CTRL_W{1'b0}};
            main_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN to use a 2-entry skid buffer with registered in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    logic             out_valid_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid_s),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );
`else
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept_s, emit_s;

    assign in_ready = ~valid_q | out_ready;

    // Single-register next state; flush beats a same-cycle accept.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        accept_s = in_valid & in_ready;
        emit_s   = valid_q & out_ready;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else if (accept_s) begin
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end else if (emit_s) begin
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_s = valid_q;
    assign out_ctrl    = ctrl_q;
    assign out_data    = data_q;
`endif

    // Backpressure counter: clear wins, flush cycles are not counted, no wrap.
    always_comb begin
        if (stall_cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && !flush &&
                     (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_s;
    assign stall_cnt = stall_cnt_q;

endmodule
